// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the imem loader
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      DONE,
      ERR
   } loader_state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   // Byte address of word number idx, counted from base.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and imem write port out of the loader
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wd;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wd
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wd
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian bytes into 32-bit words
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_en,
   output logic [31:0] word_out,
   output logic        word_full
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0] idx;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx       <= 2'd0;
         word_out  <= 32'd0;
         word_full <= 1'b0;
      end else begin
         word_full <= byte_en && (idx == LAST_IDX);
         if (byte_en) begin
            word_out[8*idx +: 8] <= byte_in;
            idx                  <= idx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into imem, holding the core in reset
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          DEPTH          = 256,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int          TIMEOUT_CYCLES = 1000000
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_reset,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [15:0]   words_loaded
);

   localparam int          HDR_BITS     = 8 * HDR_BYTES;
   localparam logic [16:0] DEPTH_W      = 17'(DEPTH);
   localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  LAST_BYTE    = 2'(BYTES_PER_WORD - 1);

   loader_state_t         state, next_state;
   logic [HDR_BITS-1:0]   n_words;
   logic [HDR_BITS-1:0]   hdr_n;
   logic [31:0]           timer;
   logic [1:0]            byte_cnt;
   logic                  rx_ready_int;
   logic                  accept;
   logic                  timed_out;
   logic                  we_int;
   logic                  asm_clear;
   logic [31:0]           word_out;
   logic                  word_full;

   assign rx_ready_int = (state == HDR0) || (state == HDR1) || (state == DATA);
   assign accept       = bus.rx_valid && rx_ready_int;
   assign hdr_n        = {bus.rx_data, n_words[7:0]};
   assign timed_out    = TIMEOUT_EN && !accept && (timer == TIMEOUT_LAST)
                         && ((state == HDR1) || (state == DATA));
   // The assembler restarts on a new load and drops any partial word on error.
   assign asm_clear    = ((state == IDLE) && start) || (state == ERR);

   word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .byte_in   (bus.rx_data),
      .byte_en   (accept && (state == DATA)),
      .word_out  (word_out),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      we_int     = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:  if (start) next_state = HDR0;
         HDR0:  if (accept) next_state = HDR1;
         HDR1: begin
            if (accept) begin
               if (hdr_n == '0)                  next_state = DONE;
               else if ({1'b0, hdr_n} > DEPTH_W) next_state = ERR;
               else                              next_state = DATA;
            end else if (timed_out) begin
               next_state = ERR;
            end
         end
         DATA: begin
            if (accept && (byte_cnt == LAST_BYTE)) next_state = WRITE;
            else if (timed_out)                    next_state = ERR;
         end
         WRITE: begin
            we_int = word_full;
            if ((words_loaded + 16'd1) == n_words) next_state = DONE;
            else                                   next_state = DATA;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         n_words      <= '0;
         timer        <= 32'd0;
         byte_cnt     <= 2'd0;
         words_loaded <= 16'd0;
         err          <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            err          <= 1'b0;
            words_loaded <= 16'd0;
            timer        <= 32'd0;
            byte_cnt     <= 2'd0;
         end
         if (next_state == ERR) err <= 1'b1;
         if (accept && (state == HDR0)) n_words[7:0]  <= bus.rx_data;
         if (accept && (state == HDR1)) n_words[15:8] <= bus.rx_data;
         if ((state == HDR1) || (state == DATA)) timer <= accept ? 32'd0 : timer + 32'd1;
         if (accept && (state == DATA)) byte_cnt <= byte_cnt + 2'd1;
         if (state == ERR) byte_cnt <= 2'd0;
         if (state == WRITE) words_loaded <= words_loaded + 16'd1;
      end
   end

   assign bus.rx_ready  = rx_ready_int;
   assign bus.imem_we   = we_int;
   assign bus.imem_addr = word_addr(BASE_ADDR, words_loaded);
   assign bus.imem_wd   = word_out;

   assign busy      = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == WRITE);
   assign cpu_reset = reset || ((state != IDLE) && (state != DONE));

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cpu_reset, busy, done, err;
   logic [15:0] words_loaded;

   imem_loader_if itf();

   imem_loader #(
      .DEPTH          (256),
      .BASE_ADDR      (32'h0),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bus          (itf),
      .cpu_reset    (cpu_reset),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   always @(negedge clk) begin
      if (itf.imem_we === 1'b1) begin
         wr_addr.push_back(itf.imem_addr);
         wr_data.push_back(itf.imem_wd);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      sync();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc = 1'b0;
      itf.rx_data  = b;
      itf.rx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = itf.rx_ready;
         @(posedge clk);
         if (acc) break;
      end
      #1;
      itf.rx_valid = 1'b0;
      if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_done(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, found}, 32'd1);
      sync();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, {31'd0, itf.rx_ready}, 32'd0);
      check({tag, "_we"},       {31'd0, itf.imem_we}, 32'd0);
      check({tag, "_addr"},     itf.imem_addr, 32'h0);
      check({tag, "_wd"},       itf.imem_wd, 32'h0);
      check({tag, "_busy"},     {31'd0, busy}, 32'd0);
      check({tag, "_done"},     {31'd0, done}, 32'd0);
      check({tag, "_err"},      {31'd0, err}, 32'd0);
      check({tag, "_words"},    {16'd0, words_loaded}, 32'd0);
      check({tag, "_cpu_rst"},  {31'd0, cpu_reset}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      int errs;
      logic [7:0] t5 [6];
      t5 = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

      reset = 1'b1;
      start = 1'b0;
      itf.rx_data  = 8'h00;
      itf.rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      sync();
      reset = 1'b0;
      @(negedge clk);
      check("rst_cpu_release", {31'd0, cpu_reset}, 32'd0);
      sync();

      // Test 1: two-word program
      pulse_start();
      @(negedge clk);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_cpu_rst", {31'd0, cpu_reset}, 32'd1);
      sync();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      @(negedge clk);
      check("t1_we_latency", {31'd0, itf.imem_we}, 32'd1);
      check("t1_we_addr", itf.imem_addr, 32'h0);
      check("t1_we_wd", itf.imem_wd, 32'h12345678);
      check("t1_we_rx_ready", {31'd0, itf.rx_ready}, 32'd0);
      sync();
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      wait_done("t1_done");
      @(negedge clk);
      check("t1_done_pulse", {31'd0, done}, 32'd0);
      check("t1_cpu_rst_after", {31'd0, cpu_reset}, 32'd0);
      check("t1_words", {16'd0, words_loaded}, 32'd2);
      check("t1_nwrites", wr_addr.size(), 32'd2);
      check("t1_addr0", wr_addr[0], 32'h0);
      check("t1_data0", wr_data[0], 32'h12345678);
      check("t1_addr1", wr_addr[1], 32'h4);
      check("t1_data1", wr_data[1], 32'hDEADBEEF);
      sync();

      // Test 2: empty program
      base = wr_addr.size();
      pulse_start();
      send_byte(8'h00); send_byte(8'h00);
      @(negedge clk);
      check("t2_done", {31'd0, done}, 32'd1);
      sync();
      @(negedge clk);
      check("t2_done_pulse", {31'd0, done}, 32'd0);
      check("t2_err", {31'd0, err}, 32'd0);
      check("t2_words", {16'd0, words_loaded}, 32'd0);
      check("t2_nwrites", wr_addr.size(), base);
      sync();

      // Test 3: header above DEPTH
      pulse_start();
      send_byte(8'h01); send_byte(8'h01);
      @(negedge clk);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_rx_ready", {31'd0, itf.rx_ready}, 32'd0);
      check("t3_busy", {31'd0, busy}, 32'd0);
      check("t3_cpu_rst_err", {31'd0, cpu_reset}, 32'd1);
      sync();
      @(negedge clk);
      check("t3_err_sticky", {31'd0, err}, 32'd1);
      check("t3_idle_cpu_rst", {31'd0, cpu_reset}, 32'd0);
      check("t3_nwrites", wr_addr.size(), base);
      sync();

      // Test 4: inter-byte timeout
      pulse_start();
      @(negedge clk);
      check("t4_err_cleared", {31'd0, err}, 32'd0);
      sync();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (err !== 1'b0 || itf.imem_we !== 1'b0) errs++;
      end
      check("t4_quiet_16", errs, 32'd0);
      @(negedge clk);
      check("t4_err_at_16", {31'd0, err}, 32'd1);
      sync();
      pulse_start();
      @(negedge clk);
      check("t4_start_clears", {31'd0, err}, 32'd0);
      sync();
      send_byte(8'h00); send_byte(8'h00);
      wait_done("t4_done");
      check("t4_nwrites", wr_addr.size(), base);

      // Test 5: random gaps and a start pulse while busy
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(1, 10)) sync();
         if (i == 3) begin
            pulse_start();
            @(negedge clk);
            check("t5_busy_after_start", {31'd0, busy}, 32'd1);
            sync();
         end
         send_byte(t5[i]);
      end
      wait_done("t5_done");
      check("t5_nwrites", wr_addr.size(), base + 1);
      check("t5_addr", wr_addr[base], 32'h0);
      check("t5_data", wr_data[base], 32'h44332211);
      check("t5_words", {16'd0, words_loaded}, 32'd1);

      // Test 6: reset in the middle of a load
      base = wr_addr.size();
      pulse_start();
      send_byte(8'h03); send_byte(8'h00);
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      reset = 1'b1;
      sync();
      @(negedge clk);
      check_reset_outputs("t6");
      check("t6_nwrites", wr_addr.size(), base + 1);
      check("t6_data", wr_data[base], 32'h04030201);
      sync();
      reset = 1'b0;
      @(negedge clk);
      check("t6_cpu_release", {31'd0, cpu_reset}, 32'd0);
      sync();
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      wait_done("t6_fresh_done");
      check("t6_fresh_nwrites", wr_addr.size(), base + 2);
      check("t6_fresh_addr", wr_addr[base + 1], 32'h0);
      check("t6_fresh_data", wr_data[base + 1], 32'hEFBEADDE);
      check("t6_fresh_err", {31'd0, err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
